// File: rtl/frame_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_mode_scheduler
// Purpose  : Steps the frame transmitter through its four Mode settings. For
//            each mode it re-arms the frame-sync FSM, waits for lock, and
//            requires LOCK_FRAMES clean locked frames before recording a pass.
//            It also keeps a sticky Fail flag (lock timeout) and a saturating
//            loss-of-sync count.
// Options  : SCHED_ABORT_ON_FAIL_EN - when defined, a lock timeout ends the
//            schedule immediately (DONE). When undefined, the schedule moves
//            on to the next mode.
// Revision : 1.0 - initial release
// ============================================================================
module frame_mode_scheduler #(
    parameter int unsigned PAYLOAD_BITS = 64,
    parameter int unsigned LOCK_FRAMES  = 4,
    parameter int unsigned TIMEOUT      = 2048,
    parameter logic [1:0]  START_MODE   = 2'b00
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] SyncState,
    input  logic       DataOutEn,
    output logic [1:0] Mode,
    output logic       TxEnable,
    output logic       ResyncReq,
    output logic       Busy,
    output logic       Done,
    output logic       Fail,
    output logic [3:0] ModePass,
    output logic [7:0] LossCount
);

    // Counter widths: timeout counter holds TIMEOUT-1, bit counter holds
    // PAYLOAD_BITS-1, frame counter holds LOCK_FRAMES.
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BIT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int unsigned FRM_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(LOCK_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_RUN       = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             fail_q, fail_d;
    logic [3:0]       pass_q, pass_d;
    logic [7:0]       loss_q, loss_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             txen_q, resync_q, busy_q, done_q;

    // Next-state and datapath update for the schedule sequencer.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        loss_d  = loss_q;
        tmo_d   = tmo_q;
        bit_d   = bit_q;
        frame_d = frame_q;

        case (state_q)
            // Start only matters when no schedule is in flight; a new schedule
            // wipes the previous results.
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_ARM;
                    mode_d  = START_MODE;
                    pass_d  = '0;
                    fail_d  = 1'b0;
                    loss_d  = '0;
                end
            end

            S_ARM: begin
                tmo_d   = '0;
                frame_d = '0;
                bit_d   = '0;
                state_d = S_WAIT_LOCK;
            end

            // Lock takes priority over a timeout landing in the same cycle.
            // Strobes seen here are not payload of a locked frame.
            S_WAIT_LOCK: begin
                if (SyncState[1]) begin
                    state_d = S_RUN;
                    frame_d = '0;
                    bit_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    fail_d  = 1'b1;
`ifdef SCHED_ABORT_ON_FAIL_EN
                    state_d = S_DONE;
`else
                    state_d = S_NEXT;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            // Loss of sync beats frame completion in the same cycle. The
            // verify state (01) is neither loss nor lock, so counting goes on.
            S_RUN: begin
                if (SyncState == 2'b00) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                    state_d = S_ARM;
                end else if (DataOutEn) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        frame_d = frame_q + 1'b1;
                        if (frame_q == FRM_LAST) begin
                            pass_d[mode_q] = 1'b1;
                            state_d        = S_NEXT;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            // The schedule always ends after mode 11; Mode never wraps.
            S_NEXT: begin
                if (mode_q == 2'b11) begin
                    state_d = S_DONE;
                end else begin
                    mode_d  = mode_q + 2'd1;
                    state_d = S_ARM;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State/counter registers; the strobe-style outputs are decoded from the
    // next state so that they are registered yet line up with the state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            mode_q   <= START_MODE;
            fail_q   <= 1'b0;
            pass_q   <= '0;
            loss_q   <= '0;
            tmo_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            txen_q   <= 1'b0;
            resync_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            loss_q   <= loss_d;
            tmo_q    <= tmo_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            txen_q   <= (state_d == S_WAIT_LOCK) || (state_d == S_RUN);
            resync_q <= (state_d == S_ARM);
            busy_q   <= (state_d == S_ARM) || (state_d == S_WAIT_LOCK) ||
                        (state_d == S_RUN) || (state_d == S_NEXT);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign Mode      = mode_q;
    assign TxEnable  = txen_q;
    assign ResyncReq = resync_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Fail      = fail_q;
    assign ModePass  = pass_q;
    assign LossCount = loss_q;

endmodule

`default_nettype wire

// File: doc/frame_mode_scheduler.md
# frame_mode_scheduler

Sequencing controller for the frame link test path: it steps the frame transmitter through its four `Mode` settings and supervises the frame-sync FSM's `State` and `DataOutEn` outputs. For each mode it waits for lock, requires a run of clean locked frames, and records pass or fail. It sits between the transmitter (drives its `Mode` and enable) and the sync FSM (observes it), and reports a per-mode pass bitmap and a loss-of-sync count.

## Interface
- `PAYLOAD_BITS`, 64: `DataOutEn` strobes per frame.
- `LOCK_FRAMES`, 4: consecutive complete locked frames required to pass a mode; must be ≥1.
- `TIMEOUT`, 2048: `Clock` cycles allowed in WAIT_LOCK before the mode fails.
- `START_MODE`, 2'b00: first mode applied after `Start`.

- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: begin a schedule; sampled in IDLE and DONE only.
- `SyncState` in 2: sync FSM state. 00 search, 01 verify, 10 locked, 11 locked-check.
- `DataOutEn` in 1: sync FSM payload-bit strobe.
- `Mode` out 2: transmitter mode.
- `TxEnable` out 1: transmitter enable.
- `ResyncReq` out 1: one-cycle pulse that forces the sync FSM to search.
- `Busy` out 1: high in ARM, WAIT_LOCK, RUN and NEXT.
- `Done` out 1: high in DONE.
- `Fail` out 1: sticky; set when any mode times out.
- `ModePass` out 4: bit *m* is set when mode *m* passes.
- `LossCount` out 8: count of loss-of-lock events, saturating at 255.

## Operation
- States: IDLE, ARM, WAIT_LOCK, RUN, NEXT, DONE. All outputs are registered.
- **IDLE**
  - `Start`=1 → ARM.
  - On that transition: `Mode`←`START_MODE`, `ModePass`←0, `Fail`←0, `LossCount`←0.
- **ARM** (exactly 1 cycle)
  - `ResyncReq`=1 and `TxEnable`=0.
  - Clear the timeout counter, the frame counter and the bit counter.
  - → WAIT_LOCK.
- **WAIT_LOCK**
  - `TxEnable`=1. The timeout counter increments every cycle.
  - `SyncState[1]`=1 → RUN, with the frame and bit counters cleared.
  - Timeout counter reaches `TIMEOUT`-1 without lock → `Fail`←1, then → NEXT. `ModePass[Mode]` stays 0.
- **RUN**
  - `TxEnable`=1. Each `DataOutEn` increments the bit counter.
  - When the bit counter reaches `PAYLOAD_BITS`-1 with `DataOutEn`=1, the bit counter wraps to 0 and the frame counter increments.
  - When the frame counter reaches `LOCK_FRAMES` → `ModePass[Mode]`←1, then → NEXT.
  - `SyncState`==00 → loss: `LossCount`+1 (saturating), then → ARM. The same mode is retried and the timeout restarts.
- **NEXT** (1 cycle)
  - `Mode`==2'b11 → DONE.
  - Otherwise `Mode`←`Mode`+1 (no wrap past 11), then → ARM.
  - The schedule always ends at mode 11. With `START_MODE`=10, only modes 10 and 11 run.
- **DONE**
  - `Done`=1 and `TxEnable`=0. Results are held.
  - `Start`=1 → ARM. Results and `Mode` reinitialise exactly as on IDLE→ARM.
- **Boundary rules**
  - `Start` while `Busy` is ignored.
  - A loss in the same cycle as the final frame completes: loss wins, no pass, retry.
  - `SyncState`==01 during RUN is neither loss nor lock; counting continues.
  - A `DataOutEn` pulse in WAIT_LOCK is not counted.

## Timing
- Reset values:
  - state IDLE
  - `Mode`=`START_MODE`
  - `TxEnable`, `ResyncReq`, `Busy`, `Done`, `Fail` = 0
  - `ModePass`=0, `LossCount`=0
- `Reset` overrides all other inputs in the cycle it is sampled. Asserting it mid-schedule aborts to IDLE on the next edge.
- `Start` sampled at edge *n* → `ResyncReq`=1 and `Busy`=1 in cycle *n*+1.
- Lock seen at edge *n* → RUN from *n*+1. That cycle's `DataOutEn` is not counted.
- Final frame strobe at edge *n* → `ModePass` bit set and NEXT in *n*+1 → ARM in *n*+2 → new `Mode` visible from *n*+2.
- Shortest per-mode time: 1 (ARM) + 1 (lock cycle) + `PAYLOAD_BITS`·`LOCK_FRAMES` strobes + 1 (NEXT).
- Counter widths:
  - timeout counter holds `TIMEOUT`-1
  - bit counter holds `PAYLOAD_BITS`-1
  - frame counter holds `LOCK_FRAMES`
  - all compares are unsigned

## Configuration
- `SCHED_ABORT_ON_FAIL_EN`
  - Defined: a WAIT_LOCK timeout sets `Fail` and goes directly to DONE. Remaining modes are not run, and their `ModePass` bits stay 0.
  - Undefined: a timeout sets `Fail` and goes to NEXT, so the schedule continues with the next mode.

## Test plan
- **Clean schedule.** Defaults; `Start` pulse; `SyncState`=10 two cycles after each ARM; continuous `DataOutEn`. Expect:
  - `Mode` steps 00→01→10→11
  - `ModePass`=4'b1111, `Fail`=0, `LossCount`=0
  - `Done`=1 after ≈4·259 cycles
- **Timeout on mode 01.** `SyncState` held at 00 while `Mode`=01. Expect:
  - `Fail`=1 after 2048 WAIT_LOCK cycles
  - without macro: `ModePass`=4'b1101
  - with macro: `Done`=1 right after the mode-01 timeout, `ModePass`=4'b0001
- **Loss mid-run.** `SyncState`→00 after 100 strobes in mode 00. Expect:
  - `LossCount`=1
  - `ResyncReq` pulses once and `Mode` stays 00
  - after the retry relocks, a pass is recorded
- **Loss on the completion edge.** `SyncState`=00 in the same cycle as the 256th strobe. Expect: no pass bit, retry, `LossCount` increments.
- **Reset and Start handling.** Assert `Reset` during RUN of mode 10. Expect:
  - next cycle: IDLE, all outputs at reset values
  - a `Start` pulse during `Busy` has no effect
- **LossCount saturation.** Force 300 losses. Expect `LossCount`=255.
